exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Stateful successor to the MEM-stage exception arbiter.
- Prioritises the committing instruction's exception vector and sampled interrupts.
- Owns EPC, BadVAddr, Cause.ExcCode/BD/IP and Status.EXL.
- Issues a registered, handshaked pipeline flush with redirect PC. Sits between the MEM stage, CP0 (mtc0 path, IE/IM source) and the fetch unit.

Parameters:
NUM_HW_INT, 6, number of hardware interrupt lines (1..8)
SYNC_STAGES, 2, synchroniser flops on each hw interrupt line (0..3; 0 = direct)
VEC_BASE, 32'hBFC0_0380, exception/interrupt redirect address
EXC_W, 9, width of exception vector input

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
exc_pc_i  in  32  PC of MEM-stage instruction
exc_pcvalid_i  in  1  MEM slot holds a real instruction
exc_in_delay_i  in  1  instruction is in a branch delay slot
exc_intr_dis_i  in  1  instruction in EX/MEM must not take an interrupt
exc_m_addr_i  in  32  data address of load/store
exc_excs_i  in  EXC_W  bit0 unused, 1 AdEL-fetch, 2 AdEL-load, 3 AdES, 4 Ov, 5 SysC, 6 Bp, 7 RI, 8 ERET
exc_hw_int_i  in  NUM_HW_INT  asynchronous hardware interrupt lines
exc_sw_int_i  in  2  Cause.IP[1:0] from CP0
exc_status_ie_i  in  1  Status.IE
exc_status_im_i  in  NUM_HW_INT+2  Status.IM
mtc0_we_i  in  1  CP0 write strobe
mtc0_sel_i  in  2  0 = EPC, 1 = Status.EXL (bit 1 of data)
mtc0_data_i  in  32  write data
flush_ack_i  in  1  fetch accepted redirect
exc_flag_o  out  1  commit suppression, combinational, this cycle
exc_code_o  out  5  Cause.ExcCode
exc_bd_o  out  1  Cause.BD
exc_ip_o  out  NUM_HW_INT+2  Cause.IP (synchronised hw, sw)
exc_exl_o  out  1  Status.EXL
exc_epc_o  out  32  EPC
exc_badvaddr_o  out  32  BadVAddr
flush_o  out  1  flush request, registered
flush_pc_o  out  32  redirect PC, registered

Behaviour:
- Reset: all outputs 0. State IDLE. Synchroniser flops cleared.
- Interrupt pending: intr = |(exc_ip_o & exc_status_im_i) & exc_status_ie_i & ~exc_exl_o & ~exc_intr_dis_i & exc_pcvalid_i.
- Priority: Intr > AdEL-fetch > AdEL-load > AdES > Ov > SysC > Bp > RI > ERET.
- ExcCodes: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
- FSM IDLE:
  - exc_flag_o = 1 when any prioritised event is present.
  - At the clock edge: state -> FLUSH, flush_o <= 1.
- FSM FLUSH:
  - exc_flag_o = 0 and all event inputs are ignored.
  - flush_o and flush_pc_o hold.
  - When flush_ack_i is sampled 1: flush_o <= 0 and state -> IDLE.
  - An ack in the first FLUSH cycle gives a 1-cycle flush pulse.
- Non-ERET event at the edge:
  - exc_code_o set; flush_pc_o <= VEC_BASE.
  - If EXL was 0: EPC <= in_delay ? pc-4 : pc, and BD <= in_delay. If EXL was 1, EPC and BD are unchanged.
  - EXL <= 1.
  - BadVAddr <= pc for AdEL-fetch, m_addr for AdEL-load/AdES; otherwise unchanged.
- ERET at the edge:
  - EXL <= 0; flush_pc_o <= EPC. If an mtc0 EPC write occurs in the same cycle, the written data is forwarded to flush_pc_o.
  - exc_code_o unchanged.
- mtc0:
  - Writes EPC or EXL at the edge when in IDLE.
  - An exception or ERET in the same cycle overrides the mtc0 write to the same field.
  - mtc0 is ignored in FLUSH.
- exc_ip_o: hw bits lag exc_hw_int_i by SYNC_STAGES cycles; sw bits are a direct copy.
- exc_pcvalid_i = 0 masks the interrupt only; synchronous exceptions are still taken.
- Reset in FLUSH: returns to IDLE, flush_o = 0 on the next cycle.
- PC-4 wraps modulo 2^32.

Test Plan:
- Reset, then SysC at pc 0x8000_1000 not in delay slot -> exc_flag_o=1 same cycle; next cycle flush_o=1, flush_pc_o=0xBFC0_0380, EPC=0x8000_1000, code=8, EXL=1.
- AdEL-load at pc 0x8000_2004, in delay slot, m_addr 0x1003 -> EPC=0x8000_2000, BD=1, BadVAddr=0x1003, code=4.
- IE=1, IM[2]=1, hw_int[0] rises -> interrupt taken exactly SYNC_STAGES cycles later (code 0). Repeat with intr_dis=1 -> no flag. Repeat with EXL=1 -> no flag.
- Flush handshake: ack held low 3 cycles -> flush_o stays high 3 cycles, RI presented during FLUSH is ignored; ack=1 -> flush_o=0 on the next cycle.
- EXL=1, then Ov at pc 0x9000_0000 -> EPC unchanged, code=12, flush to VEC_BASE. Then ERET with a same-cycle mtc0 EPC=0x8000_3000 -> flush_pc_o=0x8000_3000, EXL=0.
- Intr and AdES in the same cycle -> code=0, BadVAddr unchanged.

Source files
------------

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception/interrupt controller with registered flush handshake
module exc_ctrl #(
  parameter int          NUM_HW_INT  = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'hBFC0_0380,
  parameter int          EXC_W       = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_pcvalid_i,
  input  logic                  exc_in_delay_i,
  input  logic                  exc_intr_dis_i,
  input  logic [31:0]           exc_m_addr_i,
  input  logic [EXC_W-1:0]      exc_excs_i,
  input  logic [NUM_HW_INT-1:0] exc_hw_int_i,
  input  logic [1:0]            exc_sw_int_i,
  input  logic                  exc_status_ie_i,
  input  logic [NUM_HW_INT+1:0] exc_status_im_i,
  input  logic                  mtc0_we_i,
  input  logic [1:0]            mtc0_sel_i,
  input  logic [31:0]           mtc0_data_i,
  input  logic                  flush_ack_i,
  output logic                  exc_flag_o,
  output logic [4:0]            exc_code_o,
  output logic                  exc_bd_o,
  output logic [NUM_HW_INT+1:0] exc_ip_o,
  output logic                  exc_exl_o,
  output logic [31:0]           exc_epc_o,
  output logic [31:0]           exc_badvaddr_o,
  output logic                  flush_o,
  output logic [31:0]           flush_pc_o
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                state_q, state_nxt;
  logic [NUM_HW_INT-1:0] hw_sync;
  logic                  intr;
  logic                  ev_any, ev_eret, ev_bad_we;
  logic [4:0]            ev_code;
  logic [31:0]           ev_bad;
  logic                  take;
  logic                  mtc0_epc_we, mtc0_exl_we;
  logic                  unused_bit0;

  assign unused_bit0 = exc_excs_i[0];

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign hw_sync = exc_hw_int_i;
    end else begin : g_sync
      logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
      // Shift asynchronous interrupt lines through the synchroniser chain
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= exc_hw_int_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign hw_sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign exc_ip_o = {hw_sync, exc_sw_int_i};
  assign intr     = (|(exc_ip_o & exc_status_im_i)) & exc_status_ie_i & ~exc_exl_o
                    & ~exc_intr_dis_i & exc_pcvalid_i;

  // Priority-encode the highest event into its code and BadVAddr effect
  always_comb begin
    ev_any    = 1'b1;
    ev_eret   = 1'b0;
    ev_bad_we = 1'b0;
    ev_bad    = exc_pc_i;
    ev_code   = 5'd0;
    if (intr) begin
      ev_code = 5'd0;
    end else if (exc_excs_i[1]) begin
      ev_code   = 5'd4;
      ev_bad_we = 1'b1;
      ev_bad    = exc_pc_i;
    end else if (exc_excs_i[2]) begin
      ev_code   = 5'd4;
      ev_bad_we = 1'b1;
      ev_bad    = exc_m_addr_i;
    end else if (exc_excs_i[3]) begin
      ev_code   = 5'd5;
      ev_bad_we = 1'b1;
      ev_bad    = exc_m_addr_i;
    end else if (exc_excs_i[4]) begin
      ev_code = 5'd12;
    end else if (exc_excs_i[5]) begin
      ev_code = 5'd8;
    end else if (exc_excs_i[6]) begin
      ev_code = 5'd9;
    end else if (exc_excs_i[7]) begin
      ev_code = 5'd10;
    end else if (exc_excs_i[8]) begin
      ev_eret = 1'b1;
    end else begin
      ev_any = 1'b0;
    end
  end

  // Next-state and commit-suppression; events are only seen in IDLE
  always_comb begin
    state_nxt  = state_q;
    exc_flag_o = 1'b0;
    take       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_any) begin
          exc_flag_o = 1'b1;
          take       = 1'b1;
          state_nxt  = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_ack_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mtc0_epc_we = (state_q == IDLE) && mtc0_we_i && (mtc0_sel_i == 2'd0);
  assign mtc0_exl_we = (state_q == IDLE) && mtc0_we_i && (mtc0_sel_i == 2'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // CP0 fields and flush request; a taken event owns EXL, and a non-ERET event owns EPC
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_code_o     <= '0;
      exc_bd_o       <= 1'b0;
      exc_exl_o      <= 1'b0;
      exc_epc_o      <= '0;
      exc_badvaddr_o <= '0;
      flush_o        <= 1'b0;
      flush_pc_o     <= '0;
    end else if (take && !ev_eret) begin
      flush_o    <= 1'b1;
      flush_pc_o <= VEC_BASE;
      exc_code_o <= ev_code;
      exc_exl_o  <= 1'b1;
      if (!exc_exl_o) begin
        exc_epc_o <= exc_in_delay_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        exc_bd_o  <= exc_in_delay_i;
      end
      if (ev_bad_we) exc_badvaddr_o <= ev_bad;
    end else if (take) begin
      flush_o    <= 1'b1;
      flush_pc_o <= mtc0_epc_we ? mtc0_data_i : exc_epc_o;
      exc_exl_o  <= 1'b0;
      if (mtc0_epc_we) exc_epc_o <= mtc0_data_i;
    end else begin
      if (state_q == FLUSH && flush_ack_i) flush_o <= 1'b0;
      if (mtc0_epc_we) exc_epc_o <= mtc0_data_i;
      if (mtc0_exl_we) exc_exl_o <= mtc0_data_i[1];
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;

  localparam int          NHW = 6;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc, m_addr, mtc0_data;
  logic          pcvalid, in_delay, intr_dis, ie, mtc0_we, ack;
  logic [8:0]    excs;
  logic [NHW-1:0] hw_int;
  logic [1:0]    sw_int, mtc0_sel;
  logic [NHW+1:0] im;
  logic          flag, bd, exl, flush;
  logic [4:0]    code;
  logic [NHW+1:0] ip;
  logic [31:0]   epc, badvaddr, flush_pc;

  int n_tests = 0;
  int n_fail  = 0;

  exc_ctrl #(.NUM_HW_INT(NHW), .SYNC_STAGES(2), .VEC_BASE(VEC), .EXC_W(9)) dut (
    .clk(clk), .rst(rst),
    .exc_pc_i(pc), .exc_pcvalid_i(pcvalid), .exc_in_delay_i(in_delay),
    .exc_intr_dis_i(intr_dis), .exc_m_addr_i(m_addr), .exc_excs_i(excs),
    .exc_hw_int_i(hw_int), .exc_sw_int_i(sw_int), .exc_status_ie_i(ie),
    .exc_status_im_i(im), .mtc0_we_i(mtc0_we), .mtc0_sel_i(mtc0_sel),
    .mtc0_data_i(mtc0_data), .flush_ack_i(ack),
    .exc_flag_o(flag), .exc_code_o(code), .exc_bd_o(bd), .exc_ip_o(ip),
    .exc_exl_o(exl), .exc_epc_o(epc), .exc_badvaddr_o(badvaddr),
    .flush_o(flush), .flush_pc_o(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ack_flush();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("flush_released", {31'd0, flush}, 32'd0);
  endtask

  task automatic clear_exl();
    mtc0_we = 1'b1; mtc0_sel = 2'd1; mtc0_data = 32'd0;
    tick();
    mtc0_we = 1'b0;
    chk("mtc0_exl_clear", {31'd0, exl}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; pc = '0; m_addr = '0; mtc0_data = '0; pcvalid = 1'b0; in_delay = 1'b0;
    intr_dis = 1'b0; ie = 1'b0; mtc0_we = 1'b0; ack = 1'b0; excs = '0; hw_int = '0;
    sw_int = '0; mtc0_sel = '0; im = '0;
    tick(); tick();
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);
    chk("rst_cp0", {code, bd, exl, ip}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_badvaddr", badvaddr, 32'd0);
    chk("rst_flag", {31'd0, flag}, 32'd0);
    rst = 1'b0;

    // SysC, not in delay slot
    pc = 32'h8000_1000; pcvalid = 1'b1; excs = 9'h020;
    #1 chk("sysc_flag", {31'd0, flag}, 32'd1);
    tick();
    excs = '0;
    chk("sysc_flush", {31'd0, flush}, 32'd1);
    chk("sysc_flush_pc", flush_pc, VEC);
    chk("sysc_epc", epc, 32'h8000_1000);
    chk("sysc_code", {27'd0, code}, 32'd8);
    chk("sysc_exl_bd", {30'd0, exl, bd}, 32'b10);
    ack_flush();

    // AdEL-load in delay slot
    clear_exl();
    pc = 32'h8000_2004; in_delay = 1'b1; m_addr = 32'h1003; excs = 9'h004;
    tick();
    excs = '0; in_delay = 1'b0;
    chk("adel_epc", epc, 32'h8000_2000);
    chk("adel_bd", {31'd0, bd}, 32'd1);
    chk("adel_badvaddr", badvaddr, 32'h1003);
    chk("adel_code", {27'd0, code}, 32'd4);
    ack_flush();

    // Interrupt via hw_int[0] -> IP[2], two synchroniser cycles
    clear_exl();
    ie = 1'b1; im = 8'h04; pc = 32'h8000_5000; hw_int = 6'h01;
    #1 chk("int_lag0", {31'd0, flag}, 32'd0);
    tick();
    chk("int_lag1", {31'd0, flag}, 32'd0);
    tick();
    chk("int_flag", {31'd0, flag}, 32'd1);
    chk("int_ip", {24'd0, ip}, 32'h04);
    tick();
    hw_int = '0;
    chk("int_code", {27'd0, code}, 32'd0);
    chk("int_flush_exl", {30'd0, flush, exl}, 32'b11);
    chk("int_epc", epc, 32'h8000_5000);
    ack_flush();
    // pending interrupt with EXL=1
    hw_int = 6'h01;
    tick(); tick(); tick();
    chk("int_exl_masked", {31'd0, flag}, 32'd0);
    // pending interrupt with intr_dis=1
    intr_dis = 1'b1;
    clear_exl();
    chk("int_dis_masked", {31'd0, flag}, 32'd0);
    hw_int = '0;
    tick(); tick(); tick();
    intr_dis = 1'b0;
    #1 chk("int_gone", {31'd0, flag}, 32'd0);

    // Flush handshake with RI presented during FLUSH
    pc = 32'h8000_6000; excs = 9'h020;
    tick();
    excs = 9'h080;
    chk("hs_flag_in_flush", {31'd0, flag}, 32'd0);
    chk("hs_flush_c1", {31'd0, flush}, 32'd1);
    tick();
    chk("hs_flush_c2", {31'd0, flush}, 32'd1);
    tick();
    chk("hs_flush_c3", {31'd0, flush}, 32'd1);
    chk("hs_code_held", {27'd0, code}, 32'd8);
    excs = '0;
    ack_flush();
    chk("hs_epc", epc, 32'h8000_6000);

    // Ov with EXL=1 keeps EPC
    pc = 32'h9000_0000; excs = 9'h010;
    tick();
    excs = '0;
    chk("ov_epc_kept", epc, 32'h8000_6000);
    chk("ov_code", {27'd0, code}, 32'd12);
    chk("ov_flush_pc", flush_pc, VEC);
    ack_flush();

    // ERET with same-cycle mtc0 EPC write
    excs = 9'h100; mtc0_we = 1'b1; mtc0_sel = 2'd0; mtc0_data = 32'h8000_3000;
    #1 chk("eret_flag", {31'd0, flag}, 32'd1);
    tick();
    excs = '0; mtc0_we = 1'b0;
    chk("eret_flush_pc", flush_pc, 32'h8000_3000);
    chk("eret_exl", {31'd0, exl}, 32'd0);
    chk("eret_code_kept", {27'd0, code}, 32'd12);
    chk("eret_epc", epc, 32'h8000_3000);
    ack_flush();

    // Interrupt and AdES together
    intr_dis = 1'b1; hw_int = 6'h01; pc = 32'h8000_7000;
    tick(); tick(); tick();
    chk("both_wait", {31'd0, flag}, 32'd0);
    intr_dis = 1'b0; pcvalid = 1'b0;
    #1 chk("pcvalid_masks", {31'd0, flag}, 32'd0);
    pcvalid = 1'b1; excs = 9'h008; m_addr = 32'hDEAD;
    #1 chk("both_flag", {31'd0, flag}, 32'd1);
    tick();
    excs = '0; hw_int = '0;
    chk("both_code", {27'd0, code}, 32'd0);
    chk("both_badvaddr", badvaddr, 32'h1003);
    chk("both_flush", {31'd0, flush}, 32'd1);

    // Reset while in FLUSH
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_in_flush", {31'd0, flush}, 32'd0);
    excs = 9'h020;
    #1 chk("rst_back_idle", {31'd0, flag}, 32'd1);
    excs = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
